// File: rtl/tfe_addr_pkg.sv
`default_nettype none
// ============================================================================
// Package : tfe_addr_pkg
// Brief   : Shared feature-address types for the flow address free list.
// Rev     : 1.0  initial release
// ============================================================================
package tfe_addr_pkg;

    localparam int ADDR_W = 12;

    typedef logic [ADDR_W-1:0] fea_addr_t;

    typedef struct packed {
        fea_addr_t fwd;
        fea_addr_t rev;
    } addr_pair_t;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage : tfe_addr_pkg
`default_nettype wire

// File: rtl/flow_addr_pair_ram.sv
`default_nettype none
// ============================================================================
// Module : flow_addr_pair_ram
// Brief  : Simple dual-port pair storage, one write port, one registered read.
// Rev    : 1.0  initial release
// ============================================================================
module flow_addr_pair_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 1024,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [PTR_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [PTR_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : flow_addr_pair_ram
`default_nettype wire

// File: rtl/flow_addr_free_list.sv
`default_nettype none
// ============================================================================
// Module : flow_addr_free_list
// Brief  : Circular free pool of feature address pairs; self-fills after reset.
// Rev    : 1.0  initial release
// ============================================================================
module flow_addr_free_list #(
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 1024,
    parameter int BASE     = 0,
    parameter int R_OFFSET = 2048
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         free_fea_addr,
    input  logic [ADDR_W-1:0]         free_r_fea_addr,
    input  logic                      free_fea_addr_v,
    input  logic                      alloc_req,
    output logic [ADDR_W-1:0]         alloc_fea_addr,
    output logic [ADDR_W-1:0]         alloc_r_fea_addr,
    output logic                      alloc_v,
    output logic                      pool_ready,
    output logic [$clog2(DEPTH):0]    free_cnt,
    output logic                      err_overflow,
    output logic                      err_underflow
);

    import tfe_addr_pkg::*;

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam int                c_CNT_W    = c_PTR_W + 1;
    localparam int                c_DATA_W   = 2 * ADDR_W;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    state_t               state_q,    state_d;
    logic [c_PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [c_CNT_W-1:0]   free_cnt_q, free_cnt_d;
    logic                 alloc_v_q;
    logic                 err_ovf_q,  err_ovf_d;
    logic                 err_unf_q,  err_unf_d;

    logic                 w_grant;
    logic                 w_push;
    logic                 w_ram_we;
    logic [c_DATA_W-1:0]  w_ram_wdata;
    logic [c_DATA_W-1:0]  w_ram_rdata;
    logic [ADDR_W-1:0]    w_init_fwd;
    logic [ADDR_W-1:0]    w_init_rev;

    // During fill the write pointer doubles as the init counter: entry i gets slot i.
    assign w_init_fwd = ADDR_W'(BASE) + ADDR_W'(wr_ptr_q);
    assign w_init_rev = w_init_fwd + ADDR_W'(R_OFFSET);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        free_cnt_d  = free_cnt_q;
        err_ovf_d   = err_ovf_q;
        err_unf_d   = err_unf_q;
        w_grant     = 1'b0;
        w_push      = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_wdata = {free_fea_addr, free_r_fea_addr};

        case (state_q)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = {w_init_fwd, w_init_rev};
                wr_ptr_d    = wr_ptr_q + 1'b1;
                free_cnt_d  = free_cnt_q + 1'b1;
                if (free_fea_addr_v) begin
                    err_ovf_d = 1'b1;
                end
                if (wr_ptr_q == c_LAST_PTR) begin
                    state_d = ST_READY;
                end
            end

            ST_READY: begin
                // Full/empty decisions use the count sampled this cycle, so a
                // pair freed into an empty pool cannot be granted in the same cycle.
                w_grant = alloc_req && (free_cnt_q != '0);
                w_push  = free_fea_addr_v && (free_cnt_q != c_FULL_CNT);

                if (alloc_req && (free_cnt_q == '0)) begin
                    err_unf_d = 1'b1;
                end
                if (free_fea_addr_v && (free_cnt_q == c_FULL_CNT)) begin
                    err_ovf_d = 1'b1;
                end

                if (w_grant) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (w_push) begin
                    w_ram_we = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end

                case ({w_grant, w_push})
                    2'b10:   free_cnt_d = free_cnt_q - 1'b1;
                    2'b01:   free_cnt_d = free_cnt_q + 1'b1;
                    default: free_cnt_d = free_cnt_q;
                endcase
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            free_cnt_q <= '0;
            alloc_v_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            free_cnt_q <= free_cnt_d;
            alloc_v_q  <= w_grant;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
        end
    end

    flow_addr_pair_ram #(
        .DATA_W (c_DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (c_PTR_W)
    ) u_pair_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (w_ram_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (w_ram_wdata),
        .rd_en_i   (w_grant),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_ram_rdata)
    );

    assign alloc_fea_addr   = w_ram_rdata[c_DATA_W-1:ADDR_W];
    assign alloc_r_fea_addr = w_ram_rdata[ADDR_W-1:0];
    assign alloc_v          = alloc_v_q;
    assign pool_ready       = (state_q == ST_READY);
    assign free_cnt         = free_cnt_q;
    assign err_overflow     = err_ovf_q;
    assign err_underflow    = err_unf_q;

endmodule : flow_addr_free_list
`default_nettype wire

// File: tb/tb_flow_addr_free_list.sv
`default_nettype none
// ============================================================================
// Module : tb_flow_addr_free_list
// Brief  : Directed + randomized bench with a queue-based pool model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_flow_addr_free_list;

    localparam int AW = 12;
    localparam int DP = 8;
    localparam int BS = 0;
    localparam int RO = 2048;
    localparam int CW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ffa, fra;
    logic          fv, areq;
    logic [AW-1:0] alloc_fea_addr, alloc_r_fea_addr;
    logic          alloc_v, pool_ready, err_overflow, err_underflow;
    logic [CW-1:0] free_cnt;

    always #5 clk = ~clk;

    flow_addr_free_list #(
        .ADDR_W   (AW),
        .DEPTH    (DP),
        .BASE     (BS),
        .R_OFFSET (RO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .free_fea_addr    (ffa),
        .free_r_fea_addr  (fra),
        .free_fea_addr_v  (fv),
        .alloc_req        (areq),
        .alloc_fea_addr   (alloc_fea_addr),
        .alloc_r_fea_addr (alloc_r_fea_addr),
        .alloc_v          (alloc_v),
        .pool_ready       (pool_ready),
        .free_cnt         (free_cnt),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pool is an ordered queue of {fwd,rev} pairs.
    logic [2*AW-1:0] pool[$];
    bit              m_ready;
    int              m_init;
    bit              m_ovf, m_unf, m_v;
    logic [AW-1:0]   m_f, m_r;
    bit              chk_en = 1'b0;

    task automatic model_reset();
        pool.delete();
        m_ready = 1'b0;
        m_init  = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_v     = 1'b0;
        m_f     = '0;
        m_r     = '0;
    endtask

    task automatic model_step();
        int sz;
        logic [AW-1:0] f_init, r_init;
        m_v = 1'b0;
        if (!m_ready) begin
            if (fv) m_ovf = 1'b1;
            f_init = AW'(BS + m_init);
            r_init = AW'(BS + m_init + RO);
            pool.push_back({f_init, r_init});
            m_init++;
            if (m_init == DP) m_ready = 1'b1;
        end else begin
            sz = pool.size();
            if (areq) begin
                if (sz == 0) begin
                    m_unf = 1'b1;
                end else begin
                    {m_f, m_r} = pool.pop_front();
                    m_v = 1'b1;
                end
            end
            if (fv) begin
                if (sz == DP) m_ovf = 1'b1;
                else          pool.push_back({ffa, fra});
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("alloc_v", alloc_v, m_v);
            if (m_v) begin
                check("alloc_fea_addr", alloc_fea_addr, m_f);
                check("alloc_r_fea_addr", alloc_r_fea_addr, m_r);
            end
            check("pool_ready", pool_ready, m_ready);
            check("free_cnt", free_cnt, pool.size());
            check("err_overflow", err_overflow, m_ovf);
            check("err_underflow", err_underflow, m_unf);
        end
    end

    task automatic cyc(input bit a, input bit f, input logic [AW-1:0] fa, input logic [AW-1:0] fr);
        areq = a;
        fv   = f;
        ffa  = fa;
        fra  = fr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        areq  = 1'b0;
        fv    = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst alloc_v", alloc_v, 0);
        check("rst pool_ready", pool_ready, 0);
        check("rst free_cnt", free_cnt, 0);
        check("rst err_overflow", err_overflow, 0);
        check("rst err_underflow", err_underflow, 0);
        check("rst alloc_fea_addr", alloc_fea_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        areq  = 1'b0;
        fv    = 1'b0;
        ffa   = '0;
        fra   = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill takes exactly DEPTH cycles.
        idle(DP - 1);
        check("init pool_ready early", pool_ready, 0);
        idle(1);
        check("init pool_ready", pool_ready, 1);
        check("init free_cnt", free_cnt, 8);
        check("init errors", {err_overflow, err_underflow}, 0);

        // Drain in FIFO order, then underflow.
        for (int i = 0; i < DP; i++) begin
            cyc(1'b1, 1'b0, '0, '0);
            check("drain alloc_v", alloc_v, 1);
            check("drain fwd", alloc_fea_addr, i);
            check("drain rev", alloc_r_fea_addr, 2048 + i);
        end
        check("drain free_cnt", free_cnt, 0);
        cyc(1'b1, 1'b0, '0, '0);
        check("empty alloc_v", alloc_v, 0);
        check("empty err_underflow", err_underflow, 1);

        // Free into empty pool then allocate it back.
        cyc(1'b0, 1'b1, 12'h123, 12'h923);
        cyc(1'b1, 1'b0, '0, '0);
        check("refill alloc_v", alloc_v, 1);
        check("refill fwd", alloc_fea_addr, 12'h123);
        check("refill rev", alloc_r_fea_addr, 12'h923);

        // Simultaneous alloc+free: refused when empty, both done otherwise.
        cyc(1'b1, 1'b1, 12'h055, 12'h855);
        check("sim empty alloc_v", alloc_v, 0);
        check("sim empty free_cnt", free_cnt, 1);
        cyc(1'b0, 1'b1, 12'h066, 12'h866);
        cyc(1'b0, 1'b1, 12'h077, 12'h877);
        check("sim free_cnt 3", free_cnt, 3);
        cyc(1'b1, 1'b1, 12'h088, 12'h888);
        check("sim both fwd", alloc_fea_addr, 12'h055);
        check("sim both free_cnt", free_cnt, 3);
        cyc(1'b1, 1'b0, '0, '0);
        check("sim order fwd", alloc_fea_addr, 12'h066);

        // Overflow on a full pool leaves content untouched.
        apply_reset();
        idle(DP);
        cyc(1'b0, 1'b1, 12'hABC, 12'hDEF);
        check("full err_overflow", err_overflow, 1);
        check("full free_cnt", free_cnt, 8);
        cyc(1'b1, 1'b0, '0, '0);
        check("full first fwd", alloc_fea_addr, 0);
        check("full first rev", alloc_r_fea_addr, 12'h800);
        for (int i = 1; i < DP; i++) cyc(1'b1, 1'b0, '0, '0);

        // Reset in the middle of fill; free during fill is an overflow.
        apply_reset();
        idle(2);
        cyc(1'b0, 1'b1, 12'h111, 12'h222);
        check("init free err_overflow", err_overflow, 1);
        idle(1);
        apply_reset();
        idle(DP);
        check("refill pool_ready", pool_ready, 1);
        check("refill free_cnt", free_cnt, 8);
        check("refill err_overflow", err_overflow, 0);
        cyc(1'b1, 1'b0, '0, '0);
        check("refill first fwd", alloc_fea_addr, 0);

        // Randomized traffic with phases biased toward empty and full.
        for (int ph = 0; ph < 4; ph++) begin
            int pa;
            int pf;
            pa = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            pf = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
            for (int n = 0; n < 700; n++) begin
                if ($urandom_range(0, 599) == 0) begin
                    apply_reset();
                end else begin
                    cyc($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pf,
                        AW'($urandom), AW'($urandom));
                end
            end
        end

        idle(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_flow_addr_free_list
`default_nettype wire
